// File: rtl/hci_package.sv
// Shared HCI interconnect types: control struct, branch arbiter state and stall-counting modes.
package hci_package;

  localparam int HCI_STALL_W = 8;

  typedef struct packed {
    logic                   invert_prio;
    logic [HCI_STALL_W-1:0] low_prio_max_stall;
  } hci_interconnect_ctrl_t;

  typedef enum logic {
    ARB_NORMAL,
    ARB_BOOST
  } hci_arb_state_t;

  localparam int ARB_MODE_ANY      = 0;
  localparam int ARB_MODE_CONFLICT = 1;

endpackage

// File: rtl/hci_bank_rotmask.sv
// Mask of HWPE_WIDTH contiguous banks starting at 'start', wrapping past the last bank.
module hci_bank_rotmask #(
  parameter int N_BANKS    = 8,
  parameter int HWPE_WIDTH = 4
) (
  input  logic [$clog2(N_BANKS)-1:0] start,
  input  logic                       en,
  output logic [N_BANKS-1:0]         mask
);

  localparam int          IDX_W = $clog2(N_BANKS);
  localparam int unsigned NB    = N_BANKS;
  localparam int unsigned HW    = HWPE_WIDTH;

  // Set one bit per covered bank, modulo the bank count.
  always_comb begin
    logic [IDX_W-1:0] pos;
    mask = '0;
    pos  = '0;
    if (en) begin
      for (int unsigned k = 0; k < HW; k++) begin
        pos       = IDX_W'((32'(start) + k) % NB);
        mask[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hci_branch_prio_arbiter.sv
// Per-bank arbiter between the log (core) branch and the wide HWPE branch,
// with starvation protection that inverts priority for one cycle.
module hci_branch_prio_arbiter
  import hci_package::*;
#(
  parameter int N_BANKS        = 8,
  parameter int HWPE_WIDTH     = 4,
  parameter int BIT_BANK_INDEX = 3,
  parameter int ARBITER_MODE   = 0,
  parameter int STALL_W        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  hci_interconnect_ctrl_t    ctrl_i,
  input  logic [N_BANKS-1:0]        log_req_i,
  input  logic                      hwpe_req_i,
  input  logic [BIT_BANK_INDEX-1:0] hwpe_bank_i,
  output logic [N_BANKS-1:0]        log_gnt_o,
  output logic                      hwpe_gnt_o,
  output logic [N_BANKS-1:0]        hwpe_mask_o,
  output logic [N_BANKS-1:0]        conflict_o,
  output logic                      prio_o,
  output logic [STALL_W-1:0]        stall_cnt_o
);

  hci_arb_state_t     state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  logic               prev_invert_q;
  logic [STALL_W-1:0] max_stall;
  logic               stall_now;
  logic               boost_eff;

  assign max_stall = STALL_W'(ctrl_i.low_prio_max_stall);

  hci_bank_rotmask #(
    .N_BANKS    (N_BANKS),
    .HWPE_WIDTH (HWPE_WIDTH)
  ) u_rotmask (
    .start (hwpe_bank_i),
    .en    (hwpe_req_i),
    .mask  (hwpe_mask_o)
  );

  // Grants, effective priority and next-state; reset masks the state so
  // outputs reflect the NORMAL/0 condition while rst_i is high.
  always_comb begin
    state_d     = ARB_NORMAL;
    cnt_d       = '0;
    boost_eff   = !rst_i && (state_q == ARB_BOOST);
    prio_o      = ctrl_i.invert_prio ^ boost_eff;
    stall_cnt_o = rst_i ? '0 : cnt_q;
    conflict_o  = log_req_i & hwpe_mask_o;
    if (prio_o) begin
      hwpe_gnt_o = hwpe_req_i;
      log_gnt_o  = log_req_i & ~hwpe_mask_o;
    end else begin
      hwpe_gnt_o = hwpe_req_i & ~|conflict_o;
      log_gnt_o  = log_req_i;
    end
    if (ARBITER_MODE == ARB_MODE_CONFLICT) stall_now = |conflict_o;
    else                                   stall_now = |log_req_i & hwpe_req_i;
    // A priority change or a finished boost both fall through to NORMAL/0.
    if (ctrl_i.invert_prio == prev_invert_q && state_q == ARB_NORMAL && stall_now) begin
      if (cnt_q == max_stall)  state_d = ARB_BOOST;
      else if (cnt_q != '1)    cnt_d   = cnt_q + 1'b1;
      else                     cnt_d   = cnt_q;
    end
  end

  // State, stall counter and last-seen priority setting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ARB_NORMAL;
      cnt_q         <= '0;
      prev_invert_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_invert_q <= ctrl_i.invert_prio;
    end
  end

endmodule
